ex_muldiv: RTL and testbench

- Parametrised iterative multiply/divide unit for the RV32M/RV64M extension.
- Sits beside the single-cycle ALU in the EX stage. Accepts one operation from id_ex_reg, holds the EX stage via a stall request to fc while iterating, then returns the result and destination register for ex_mem_reg.
- Generalises the EX datapath to XLEN-wide operands and multi-cycle operation with flush support.

---
 rtl/ex_muldiv_pkg.sv | 25 ++
 rtl/ex_muldiv_iter.sv | 85 ++++++++
 rtl/ex_muldiv.sv | 175 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared op codes and FSM state encodings for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Radix-2 datapath: shift-add multiply (2*XLEN product) and restoring divide on operand magnitudes.
// MULDIV_EARLY_OUT_EN adds a remaining-multiplier-bits zero detect output.
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   opx_i,
  input  logic [XLEN-1:0]   opy_i,
  input  logic [XLEN-1:0]   rem_i,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN-1:0]   quot_o,
  output logic [XLEN-1:0]   rem_o
`ifdef MULDIV_EARLY_OUT_EN
  ,
  output logic              mplier_last_o
`endif
);

  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN:0]     trial, diff;

  // mplier_q doubles as the multiplier shifter and the dividend/quotient shifter;
  // mcand_q[XLEN-1:0] holds the divisor during a divide.
  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    trial    = '0;
    diff     = '0;
    if (load_i) begin
      prod_d   = '0;
      mcand_d  = {{XLEN{1'b0}}, opy_i};
      mplier_d = opx_i;
      rem_d    = rem_i;
    end else if (step_i) begin
      if (is_div_i) begin
        trial = {rem_q, mplier_q[XLEN-1]};
        diff  = trial - {1'b0, mcand_q[XLEN-1:0]};
        if (!diff[XLEN]) begin
          rem_d    = diff[XLEN-1:0];
          mplier_d = {mplier_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d    = trial[XLEN-1:0];
          mplier_d = {mplier_q[XLEN-2:0], 1'b0};
        end
      end else begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
    end
  end

  assign prod_o = prod_q;
  assign quot_o = mplier_q;
  assign rem_o  = rem_q;

`ifdef MULDIV_EARLY_OUT_EN
  // True when the step taken this cycle consumes the last set multiplier bit.
  assign mplier_last_o = (mplier_q[XLEN-1:1] == '0);
`endif

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: FSM, counter, flush and stall control.
// Optional MULDIV_EARLY_OUT_EN ends multiplies once the multiplier bits are exhausted.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            idex_md_start_i,
  input  logic [2:0]      idex_md_op_i,
  input  logic [XLEN-1:0] idex_op_a_i,
  input  logic [XLEN-1:0] idex_op_b_i,
  input  logic [4:0]      idex_reg_waddr_i,
  input  logic            fc_flush_ex_i,
  output logic            ex_md_stall_o,
  output logic            ex_md_busy_o,
  output logic            ex_md_done_o,
  output logic [XLEN-1:0] ex_md_result_o,
  output logic [4:0]      ex_md_reg_waddr_o
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  md_op_e            op_q, op_d;
  logic              sign_q, sign_d;
  logic [4:0]        wlat_q, wlat_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [XLEN-1:0]   result_q, result_d;

  md_op_e            op_in;
  logic              in_div, a_neg, b_neg, special, ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              load, step;
  logic [XLEN-1:0]   ld_x, ld_y, ld_rem;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot, rem, quot_fix, rem_fix, final_res;
  logic              done_int;
`ifdef MULDIV_EARLY_OUT_EN
  logic              mplier_last;
`endif

  always_comb begin
    op_in   = md_op_e'(idex_md_op_i);
    in_div  = md_is_div(op_in);
    a_neg   = (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && idex_op_a_i[XLEN-1];
    b_neg   = (op_in inside {MD_MULH, MD_DIV, MD_REM}) && idex_op_b_i[XLEN-1];
    a_mag   = a_neg ? -idex_op_a_i : idex_op_a_i;
    b_mag   = b_neg ? -idex_op_b_i : idex_op_b_i;
    ovf     = (op_in inside {MD_DIV, MD_REM}) && (idex_op_a_i == XMIN) && (idex_op_b_i == '1);
    special = in_div && ((idex_op_b_i == '0) || ovf);
  end

  always_comb begin
    prod_fix = sign_q ? -prod : prod;
    quot_fix = sign_q ? -quot : quot;
    rem_fix  = sign_q ? -rem  : rem;
    case (op_q)
      MD_MUL:                       final_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              final_res = quot_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_d   = sign_q;
    wlat_d   = wlat_q;
    waddr_d  = waddr_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    ld_x     = in_div ? a_mag : b_mag;
    ld_y     = in_div ? b_mag : a_mag;
    ld_rem   = '0;
    case (state_q)
      MD_IDLE: begin
        if (idex_md_start_i) begin
          op_d   = op_in;
          wlat_d = idex_reg_waddr_i;
          cnt_d  = '0;
          load   = 1'b1;
          if (special) begin
            // Preload quotient/remainder so the DONE mux needs no special path.
            state_d = MD_DONE;
            sign_d  = 1'b0;
            ld_x    = ovf ? XMIN : '1;
            ld_rem  = ovf ? '0 : idex_op_a_i;
          end else begin
            state_d = MD_CALC;
            sign_d  = (op_in inside {MD_REM}) ? a_neg : (a_neg ^ b_neg);
          end
        end
      end
      MD_CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = MD_DONE;
`ifdef MULDIV_EARLY_OUT_EN
        if (!md_is_div(op_q) && mplier_last) state_d = MD_DONE;
`endif
      end
      MD_DONE: begin
        result_d = final_res;
        waddr_d  = wlat_q;
        state_d  = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (fc_flush_ex_i) begin
      state_d  = MD_IDLE;
      cnt_d    = '0;
      op_d     = op_q;
      sign_d   = sign_q;
      wlat_d   = wlat_q;
      waddr_d  = waddr_q;
      result_d = result_q;
      load     = 1'b0;
      step     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      sign_q   <= 1'b0;
      wlat_q   <= '0;
      waddr_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      wlat_q   <= wlat_d;
      waddr_q  <= waddr_d;
      result_q <= result_d;
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load),
    .step_i        (step),
    .is_div_i      (md_is_div(op_q)),
    .opx_i         (ld_x),
    .opy_i         (ld_y),
    .rem_i         (ld_rem),
    .prod_o        (prod),
    .quot_o        (quot),
    .rem_o         (rem)
`ifdef MULDIV_EARLY_OUT_EN
    ,
    .mplier_last_o (mplier_last)
`endif
  );

  // Result is forwarded in the DONE cycle itself, since stall drops there.
  assign done_int          = (state_q == MD_DONE) && !fc_flush_ex_i;
  assign ex_md_done_o      = done_int;
  assign ex_md_result_o    = done_int ? final_res : result_q;
  assign ex_md_reg_waddr_o = done_int ? wlat_q : waddr_q;
  assign ex_md_busy_o      = (state_q != MD_IDLE);
  assign ex_md_stall_o     = (idex_md_start_i && (state_q == MD_IDLE)) || (state_q == MD_CALC);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (XLEN=32), honours MULDIV_EARLY_OUT_EN for multiply latency.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  wa_i = '0;
  logic        stall, busy, done;
  logic [31:0] result;
  logic [4:0]  waddr;
  int          checks = 0;
  int          failures = 0;
  logic        seen_done;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .idex_md_start_i   (start),
    .idex_md_op_i      (op),
    .idex_op_a_i       (a),
    .idex_op_b_i       (b),
    .idex_reg_waddr_i  (wa_i),
    .fc_flush_ex_i     (flush),
    .ex_md_stall_o     (stall),
    .ex_md_busy_o      (busy),
    .ex_md_done_o      (done),
    .ex_md_result_o    (result),
    .ex_md_reg_waddr_o (waddr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Multiply latency: early-out finishes once the multiplier magnitude's top set bit is consumed.
  function automatic int mul_lat(input logic [2:0] o, input logic [31:0] bv);
    logic [31:0] m;
    int k;
    m = (o == 3'd1 && bv[31]) ? -bv : bv;
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
    return ((k < 1) ? 1 : k) + 1;
`else
    return 33;
`endif
  endfunction

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [4:0] w, input logic [31:0] exp,
                       input int exp_lat);
    int lat;
    logic hold_ok;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = av; b = bv; wa_i = w;
    @(negedge clk);
    chk({tag, ".stall_c0"}, 64'(stall), 64'(1));
    lat = -1;
    hold_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (!stall || !busy) hold_ok = 1'b0;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".stall_hold"}, 64'(hold_ok), 64'(1));
    chk({tag, ".result"}, 64'(result), 64'(exp));
    chk({tag, ".waddr"}, 64'(waddr), 64'(w));
    chk({tag, ".stall_done"}, 64'(stall), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_after"}, 64'(busy), 64'(0));
    chk({tag, ".held"}, 64'(result), 64'(exp));
  endtask

  initial begin
    #2;
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.stall", 64'(stall), 64'(0));
    chk("rst.result", 64'(result), 64'(0));
    chk("rst.waddr", 64'(waddr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mul",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, mul_lat(3'd0, 32'hFFFF_FFFD));
    do_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, mul_lat(3'd1, 32'h8000_0000));
    do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, mul_lat(3'd3, 32'hFFFF_FFFF));
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, mul_lat(3'd2, 32'h0000_0002));
    do_op("div",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD, 33);
    do_op("rem",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 33);
    do_op("divu",   3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        33);
    do_op("remu",   3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         33);
    do_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    do_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1);
    do_op("divu0",  3'd5, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1);
    do_op("remu0",  3'd7, 32'd5,         32'd0,         5'd16, 32'd5,         1);

    // Flush on cycle 10 of a signed divide.
    seen_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7; wa_i = 5'd20;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush.done_mask", 64'(done), 64'(0));
    chk("flush.busy_c10", 64'(busy), 64'(1));
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("flush.busy_next", 64'(busy), 64'(0));
    chk("flush.result", 64'(result), 64'(5));
    chk("flush.waddr", 64'(waddr), 64'(16));
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("flush.no_done", 64'(seen_done), 64'(0));

    do_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12, mul_lat(3'd0, 32'd4));

    // Flush landing in the DONE cycle of a special divide.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; a = 32'd5; b = 32'd0; wa_i = 5'd22;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flushdone.done", 64'(done), 64'(0));
    chk("flushdone.result", 64'(result), 64'(12));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flushdone.busy", 64'(busy), 64'(0));
    chk("flushdone.waddr", 64'(waddr), 64'(21));

    // Flush coincident with start: the op must not be accepted.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2; wa_i = 5'd23;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flushstart.busy", 64'(busy), 64'(0));

    // Asynchronous reset in the middle of a multiply.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'hFFFF_FFFF; wa_i = 5'd24;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("arst.busy", 64'(busy), 64'(0));
    chk("arst.done", 64'(done), 64'(0));
    chk("arst.stall", 64'(stall), 64'(0));
    chk("arst.result", 64'(result), 64'(0));
    chk("arst.waddr", 64'(waddr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mul_1x1", 3'd0, 32'd1, 32'd1, 5'd25, 32'd1, mul_lat(3'd0, 32'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
